// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring DIV/DIVU sequencer for HI/LO.
// Ports: clk/rst (sync, active-high); startE/signedE/annulE/srcaE/srcbE are execute-stage
// request inputs; stallE holds F/D/E, hilo_weE strobes hiE (remainder)/loE (quotient),
// busy flags any state other than IDLE.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic             annulE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             stallE,
  output logic             hilo_weE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n, a_abs, b_abs;
  logic [WIDTH:0] trial;
  logic [CW-1:0] count;
  logic qsign, rsign, go;
  assign go = state == IDLE && startE && !annulE;
  assign a_abs = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign b_abs = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;
  // Shifted remainder needs WIDTH+1 bits; bit WIDTH of the difference is the borrow.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  assign rem_n = trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign stallE = go || state == BUSY;
  // Flush in DONE suppresses the write in the same cycle.
  assign hilo_weE = state == DONE && !annulE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      count <= '0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      hiE <= '0;
      loE <= '0;
    end else if (annulE && state != IDLE) begin
      state <= IDLE;
    end else if (go) begin
      if (srcbE == '0) begin
        state <= DONE;
        loE <= '1;
        hiE <= srcaE;
      end else begin
        state <= BUSY;
        rem <= '0;
        quo <= a_abs;
        dvs <= b_abs;
        count <= CW'(WIDTH);
        qsign <= signedE && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
        rsign <= signedE && srcaE[WIDTH-1];
      end
    end else if (state == BUSY) begin
      rem <= rem_n;
      quo <= quo_n;
      count <= count - 1'b1;
      if (count == CW'(1)) begin
        state <= DONE;
        loE <= qsign ? -quo_n : quo_n;
        hiE <= rsign ? -rem_n : rem_n;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule
